// File: rtl/expr_lane_pkg.sv
// Shared types for the multi-lane expression pipeline: opcode encoding,
// sign-select bit positions and the per-lane result record.
// Types only; no timing or handshake of its own.
package expr_lane_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_MUL    = 4'd2,
        OP_DIV    = 4'd3,
        OP_MOD    = 4'd4,
        OP_AND    = 4'd5,
        OP_OR     = 4'd6,
        OP_XNOR   = 4'd7,
        OP_SHL    = 4'd8,
        OP_SHR    = 4'd9,
        OP_SRA    = 4'd10,
        OP_LT     = 4'd11,
        OP_EQ     = 4'd12,
        OP_REDOR  = 4'd13,
        OP_REDXOR = 4'd14,
        OP_TERN   = 4'd15
    } expr_op_t;

    localparam int SGN_A = 1;
    localparam int SGN_B = 0;

    // Widest legal lane; narrower lanes zero-extend into the record.
    localparam int MAX_W = 16;

    typedef struct packed {
        logic [MAX_W-1:0] data;
        logic             dz;
    } lane_res_t;

endpackage

// File: rtl/expr_lane_alu.sv
// Single-lane expression evaluator with Verilog signed/unsigned context rules.
// Latency: purely combinational. Backpressure: none, owned by the caller.
// EXPR_LANE_SAT_EN: ADD/SUB saturate instead of wrapping.
module expr_lane_alu
    import expr_lane_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  expr_op_t         op,
    input  logic [1:0]       sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             dz
);

    logic                    sctx;
    logic                    b_zero;
    logic                    shift_big;
    logic                    lt;
    logic signed [WIDTH:0]   ea;
    logic signed [WIDTH:0]   eb;
    logic signed [WIDTH:0]   div_b;
    logic [WIDTH-1:0]        quo;
    logic [WIDTH-1:0]        rem;
    logic [WIDTH-1:0]        sra_v;

`ifdef EXPR_LANE_SAT_EN
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};

    logic signed [WIDTH:0] sum;
    logic signed [WIDTH:0] dif;

    assign sum = ea + eb;
    assign dif = ea - eb;

    // One extra bit holds the exact result; clamp if it does not fit.
    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] v,
                                             input logic sc,
                                             input logic is_sub);
        if (sc) begin
            if (v[WIDTH] != v[WIDTH-1])
                return v[WIDTH] ? SMIN : SMAX;
            return v[WIDTH-1:0];
        end
        if (v[WIDTH])
            return is_sub ? '0 : '1;
        return v[WIDTH-1:0];
    endfunction
`endif

    always_comb begin
        sctx      = sgn[SGN_A] & sgn[SGN_B];
        ea        = {sctx & a[WIDTH-1], a};
        eb        = {sctx & b[WIDTH-1], b};
        b_zero    = (b == '0);
        div_b     = b_zero ? {{WIDTH{1'b0}}, 1'b1} : eb;
        // The extra bit lets signed MIN/-1 produce +2^(W-1), which truncates back to MIN.
        quo       = WIDTH'(ea / div_b);
        rem       = WIDTH'(ea % div_b);
        lt        = (ea < eb);
        shift_big = (32'(b) >= WIDTH);
        if (shift_big)
            sra_v = {WIDTH{sgn[SGN_A] & a[WIDTH-1]}};
        else if (sgn[SGN_A])
            sra_v = $signed(a) >>> b;
        else
            sra_v = a >> b;
    end

    always_comb begin
        y  = '0;
        dz = 1'b0;
        case (op)
`ifdef EXPR_LANE_SAT_EN
            OP_ADD:    y = sat(sum, sctx, 1'b0);
            OP_SUB:    y = sat(dif, sctx, 1'b1);
`else
            OP_ADD:    y = a + b;
            OP_SUB:    y = a - b;
`endif
            OP_MUL:    y = a * b;
            OP_DIV: begin
                if (b_zero) dz = 1'b1;
                else        y  = quo;
            end
            OP_MOD: begin
                if (b_zero) dz = 1'b1;
                else        y  = rem;
            end
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XNOR:   y = ~(a ^ b);
            OP_SHL:    y = shift_big ? '0 : a << b;
            OP_SHR:    y = shift_big ? '0 : a >> b;
            OP_SRA:    y = sra_v;
            OP_LT:     y = WIDTH'(lt);
            OP_EQ:     y = WIDTH'(a == b);
            OP_REDOR:  y = WIDTH'(|a);
            OP_REDXOR: y = WIDTH'(^a);
            OP_TERN:   y = (a != '0) ? b : ~b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/expr_lane_pipe.sv
// LANES-wide expression pipeline: S1 holds operands, S2 holds lane results.
// Latency 2 cycles, throughput 1/cycle; in_ready follows out_ready combinationally.
// Stalls hold both stages; EXPR_LANE_SAT_EN selects saturating ADD/SUB in the lanes.
module expr_lane_pipe
    import expr_lane_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int LANES = 6,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_op,
    input  logic [1:0]             in_sgn,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_y,
    output logic [LANES-1:0]       out_dz,
    output logic [CNT_W-1:0]       op_count
);

    logic                   s1_full;
    logic                   s2_full;
    logic                   s2_adv;
    logic                   s2_load;
    logic                   accept;
    expr_op_t               s1_op;
    logic [1:0]             s1_sgn;
    logic [LANES*WIDTH-1:0] s1_a;
    logic [LANES*WIDTH-1:0] s1_b;

    // S2 can take new data when empty or draining this cycle; S1 likewise via S2.
    assign s2_adv    = !s2_full || out_ready;
    assign s2_load   = s1_full && s2_adv;
    assign in_ready  = !s1_full || s2_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_full  <= 1'b0;
            s2_full  <= 1'b0;
            s1_op    <= OP_ADD;
            s1_sgn   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            op_count <= '0;
        end else begin
            if (accept) begin
                s1_op    <= expr_op_t'(in_op);
                s1_sgn   <= in_sgn;
                s1_a     <= in_a;
                s1_b     <= in_b;
                op_count <= op_count + CNT_W'(1);
            end
            s1_full <= accept || (s1_full && !s2_adv);
            s2_full <= s2_load || (s2_full && !out_ready);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [WIDTH-1:0] alu_y;
        logic             alu_dz;
        lane_res_t        res_q;

        expr_lane_alu #(.WIDTH(WIDTH)) u_alu (
            .op  (s1_op),
            .sgn (s1_sgn),
            .a   (s1_a[l*WIDTH +: WIDTH]),
            .b   (s1_b[l*WIDTH +: WIDTH]),
            .y   (alu_y),
            .dz  (alu_dz)
        );

        always_ff @(posedge clk) begin
            if (reset)
                res_q <= '0;
            else if (s2_load)
                res_q <= '{data: MAX_W'(alu_y), dz: alu_dz};
        end

        assign out_y[l*WIDTH +: WIDTH] = res_q.data[WIDTH-1:0];
        assign out_dz[l]               = res_q.dz;

        if (WIDTH < MAX_W) begin : g_pad
            always_comb assert (res_q.data[MAX_W-1:WIDTH] == '0);
        end
    end

endmodule

// File: tb/tb_expr_lane_pipe.sv
// Scoreboard bench for expr_lane_pipe: directed corner vectors plus randomized traffic
// checked against an integer-arithmetic reference model.
module tb_expr_lane_pipe;

    localparam int W    = 6;
    localparam int L    = 6;
    localparam int CW   = 16;
    localparam int VW   = W * L;
    localparam int MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [1:0]    in_sgn;
    logic [VW-1:0] in_a;
    logic [VW-1:0] in_b;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [VW-1:0] out_y;
    logic [L-1:0]  out_dz;
    logic [CW-1:0] op_count;

    typedef struct {
        logic [VW-1:0] y;
        logic [L-1:0]  dz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    bit   rand_ready = 1'b0;
    bit   forced_ready = 1'b1;

    expr_lane_pipe #(.WIDTH(W), .LANES(L), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_sgn(in_sgn), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_dz(out_dz), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic int sx(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    // Reference lane: operands become integers under the chosen sign context.
    function automatic void lane_model(input int op, input int sgn, input int a, input int b,
                                       output int y, output bit dz);
        int va, vb, r, lo, hi;
        bit sc;
        sc = (sgn == 3);
        va = sc ? sx(a) : a;
        vb = sc ? sx(b) : b;
        lo = sc ? -(1 << (W - 1)) : 0;
        hi = sc ? (1 << (W - 1)) - 1 : MASK;
        dz = 1'b0;
        r  = 0;
        case (op)
`ifdef EXPR_LANE_SAT_EN
            0:  r = clamp(va + vb, lo, hi);
            1:  r = clamp(va - vb, lo, hi);
`else
            0:  r = va + vb;
            1:  r = va - vb;
`endif
            2:  r = va * vb;
            3:  if (vb == 0) dz = 1'b1; else r = va / vb;
            4:  if (vb == 0) dz = 1'b1; else r = va % vb;
            5:  r = a & b;
            6:  r = a | b;
            7:  r = ~(a ^ b);
            8:  r = (b >= W) ? 0 : a << b;
            9:  r = (b >= W) ? 0 : a >> b;
            10: if ((sgn & 2) != 0) r = (b >= W) ? ((sx(a) < 0) ? MASK : 0) : (sx(a) >>> b);
                else r = (b >= W) ? 0 : a >> b;
            11: r = (va < vb) ? 1 : 0;
            12: r = (a == b) ? 1 : 0;
            13: r = (a != 0) ? 1 : 0;
            14: r = $countones(a) & 1;
            default: r = (a != 0) ? b : ~b;
        endcase
        y = r & MASK;
    endfunction

    function automatic exp_t model(input int op, input int sgn, input logic [VW-1:0] a,
                                   input logic [VW-1:0] b);
        exp_t e;
        int   y;
        bit   dz;
        for (int l = 0; l < L; l++) begin
            lane_model(op, sgn, int'(a[l*W +: W]), int'(b[l*W +: W]), y, dz);
            e.y[l*W +: W] = y[W-1:0];
            e.dz[l]       = dz;
        end
        return e;
    endfunction

    function automatic logic [VW-1:0] rep(input logic [W-1:0] v);
        return {L{v}};
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int l = 0; l < L; l++) begin
            case ($urandom_range(0, 7))
                0:       v[l*W +: W] = '0;
                1:       v[l*W +: W] = W'(MASK);
                2:       v[l*W +: W] = W'(1 << (W - 1));
                3:       v[l*W +: W] = W'($urandom_range(W - 1, W + 2));
                default: v[l*W +: W] = W'($urandom);
            endcase
        end
        return v;
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted.
    task automatic drive(input logic [3:0] op, input logic [1:0] sg, input logic [VW-1:0] a,
                         input logic [VW-1:0] b, input exp_t e);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_sgn   = sg;
        in_a     = a;
        in_b     = b;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                ok = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) fail("accept_timeout");
        else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [1:0] sg, input logic [VW-1:0] a,
                        input logic [VW-1:0] b);
        drive(op, sg, a, b, model(int'(op), int'(sg), a, b));
    endtask

    task automatic send_k(input logic [3:0] op, input logic [1:0] sg, input logic [VW-1:0] a,
                          input logic [VW-1:0] b, input logic [VW-1:0] ey, input logic [L-1:0] edz);
        exp_t e;
        e.y  = ey;
        e.dz = edz;
        drive(op, sg, a, b, e);
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
    end

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got y=%0h with empty scoreboard", out_y);
            end else begin
                mon_e = sb.pop_front();
                check("out_y", 64'(out_y), 64'(mon_e.y));
                check("out_dz", 64'(out_dz), 64'(mon_e.dz));
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] va, vb, ey;
        int n_rand;
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_sgn = '0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_y", 64'(out_y), 0);
        check("rst_out_dz", 64'(out_dz), 0);
        check("rst_op_count", 64'(op_count), 0);
        reset = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", 64'(in_ready), 1);
        @(posedge clk);
        #1;

        // Signed ADD with exact 2-cycle latency.
        send_k(4'd0, 2'b11, rep(6'h3D), rep(6'h05), rep(6'h02), '0);
        check("lat_cycle1_idle", 64'(out_valid), 0);
        @(posedge clk);
        #1;
        check("lat_cycle2_valid", 64'(out_valid), 1);

        send_k(4'd11, 2'b10, rep(6'h3F), rep(6'h01), rep(6'h00), '0);
        send_k(4'd11, 2'b11, rep(6'h3F), rep(6'h01), rep(6'h01), '0);

        va = rep(6'd9);
        vb = rep(6'd3);
        vb[2*W +: W] = '0;
        ey = rep(6'd3);
        ey[2*W +: W] = '0;
        send_k(4'd3, 2'b00, va, vb, ey, 6'b000100);

        send_k(4'd10, 2'b10, rep(6'h20), rep(6'd7), rep(6'h3F), '0);
        send_k(4'd8, 2'b10, rep(6'h20), rep(6'd7), rep(6'h00), '0);
        send_k(4'd3, 2'b11, rep(6'h20), rep(6'h3F), rep(6'h20), '0);
`ifdef EXPR_LANE_SAT_EN
        send_k(4'd0, 2'b11, rep(6'h1F), rep(6'h01), rep(6'h1F), '0);
`else
        send_k(4'd0, 2'b11, rep(6'h1F), rep(6'h01), rep(6'h20), '0);
`endif
        drain();

        // Backpressure: two fill the pipe, the third waits for out_ready.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        forced_ready = 1'b0;
        @(posedge clk);
        #1;
        send(4'd2, 2'b11, rand_vec(), rand_vec());
        send(4'd1, 2'b01, rand_vec(), rand_vec());
        fork
            send(4'd4, 2'b11, rand_vec(), rand_vec());
            begin
                @(negedge clk);
                check("bp_in_ready_low", 64'(in_ready), 0);
                check("bp_count_2", 64'(op_count), 2);
                check("bp_out_valid", 64'(out_valid), 1);
                @(posedge clk);
                #1;
                forced_ready = 1'b1;
            end
        join
        drain();
        check("bp_count_3", 64'(op_count), 3);

        // Reset with two transactions in flight discards them.
        forced_ready = 1'b0;
        @(posedge clk);
        #1;
        send(4'd5, 2'b00, rand_vec(), rand_vec());
        send(4'd6, 2'b00, rand_vec(), rand_vec());
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 0);
        check("mid_rst_op_count", 64'(op_count), 0);
        check("mid_rst_out_y", 64'(out_y), 0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(in_ready), 1);
        @(posedge clk);
        #1;
        forced_ready = 1'b1;

        // Randomized traffic with random output stalls and input gaps.
        rand_ready = 1'b1;
        n_rand = 400;
        for (int i = 0; i < n_rand; i++) begin
            send(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), rand_vec(), rand_vec());
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        drain();
        check("rand_op_count", 64'(op_count), 64'(n_rand));
        check("sb_empty", 64'(sb.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/expr_lane_pipe.md
Name: expr_lane_pipe

Overview:
- Parametrised, pipelined successor to the flat combinational expression blocks in the regression suite.
- Evaluates one selectable Verilog-semantics expression across LANES independent lanes of WIDTH-bit operands.
- Follows Verilog's signed/unsigned context rules, with a valid/ready handshake on input and output.
- Used as a sequential stress target for mixed-sign arithmetic and width truncation through registers.

Parameters:
- WIDTH, 6, bits per lane operand and result (legal range 2 to 16).
- LANES, 6, number of parallel lanes.
- CNT_W, 16, width of the accepted-transaction counter.

Ports:
- clk  in  1  clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input transaction.
- in_op  in  4  opcode, shared by all lanes.
- in_sgn  in  2  bit1: operand a signed; bit0: operand b signed.
- in_a  in  LANES*WIDTH  lane operands a; lane 0 in the LSBs.
- in_b  in  LANES*WIDTH  lane operands b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  LANES*WIDTH  lane results.
- out_dz  out  LANES  per-lane divide/modulo-by-zero flag.
- op_count  out  CNT_W  number of accepted input transactions; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_y=0, out_dz=0, op_count=0, and both pipeline stages are emptied.
- Reset asserted mid-operation discards in-flight data. in_ready=1 in the first cycle after reset deasserts.
- Handshake:
  - An input is accepted when in_valid&&in_ready. An output is consumed when out_valid&&out_ready.
  - Payload and valid are held stable while valid&&!ready.
- Pipeline:
  - Two stages. S1 registers the operands; S2 registers the computed result.
  - Latency is exactly 2 cycles from acceptance to out_valid when there is no backpressure.
  - Each stage loads when it is empty or when its contents advance in the same cycle.
  - in_ready = !S1_full || (!S2_full || out_ready). in_ready may depend combinationally on out_ready.
  - Throughput is 1 per cycle. Order is preserved and no transaction is lost or duplicated.
- Counter: op_count increments on every acceptance, including when acceptance and output consumption happen in the same cycle.
- Sign context (lane op is signed only if in_sgn==2'b11, else both operands are treated as unsigned):
  - Applies to ADD, SUB, MUL, DIV, MOD, LT and TERN.
  - Shifts use a's sign only; the shift amount b is always unsigned.
- Opcodes (results are truncated to WIDTH):
  - 0 ADD, 1 SUB, 2 MUL (low WIDTH bits).
  - 3 DIV: truncates toward zero; signed MIN/-1 wraps to MIN.
  - 4 MOD: result takes the dividend's sign.
  - 5 AND, 6 OR, 7 XNOR.
  - 8 SHL, 9 SHR (logical).
  - 10 SRA: arithmetic only if in_sgn[1], else logical.
  - 11 LT, 12 EQ, 13 REDOR(a), 14 REDXOR(a). These produce a 1-bit result, zero-extended.
  - 15 TERN: (a!=0) ? b : ~b.
- Shift boundary: if b>=WIDTH, SHL/SHR give 0 and SRA gives all copies of a's MSB.
- Divide by zero (DIV or MOD with b==0): lane result 0 and out_dz[lane]=1. out_dz is otherwise 0.

Optional Feature:
- Macro EXPR_LANE_SAT_EN.
- When defined: ADD and SUB saturate. Signed saturation is to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; unsigned saturation is to [0, 2^WIDTH-1].
- When undefined: ADD and SUB wrap modulo 2^WIDTH.
- All other opcodes are unchanged either way.

Decomposition:
- Package expr_lane_pkg holds:
  - the opcode enum expr_op_t (4 bits, values above);
  - localparams SGN_A=1 and SGN_B=0;
  - a lane result struct {data, dz}.
- Sub-module expr_lane_alu: purely combinational single-lane evaluator with inputs op, sgn, a and b, and outputs y and dz. It is instantiated LANES times via generate between S1 and S2.
- The top level owns the handshake, stage registers and counter.

Test Plan:
- Signed ADD (WIDTH=6): a=6'h3D (-3), b=6'h05, sgn=2'b11 -> y=6'h02, dz=0, out_valid exactly 2 cycles after acceptance.
- Mixed-sign LT: a=6'h3F, b=6'h01. With sgn=2'b10 -> y=0 (unsigned 63<1). With sgn=2'b11 -> y=1.
- DIV by zero on lane 2 only (b lane2=0, other lanes b=3, a=9, unsigned) -> lane2 y=0, out_dz=6'b000100; other lanes y=3.
- Backpressure: out_ready=0, present 3 back-to-back transactions -> 2 accepted, then in_ready=0. Release out_ready -> results emerge in order, 3rd is accepted, op_count=3.
- SRA/shift boundary: a=6'h20 signed, b=7 -> SRA y=6'h3F, SHL y=0. Signed DIV 6'h20/6'h3F -> y=6'h20.
- Saturation: ADD signed 6'h1F+6'h01 -> y=6'h1F with EXPR_LANE_SAT_EN, y=6'h20 without. Reset asserted with 2 in flight -> out_valid=0 and op_count=0 on the next cycle.
